// File: rtl/fetch_stage_if.sv
`default_nettype none
// =============================================================================
// fetch_stage_if : fetch-stage bus (hazard/redirect inputs, IM port, IF/ID out)
// Revision: 1.0
// =============================================================================
interface fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] im_address;
    logic [31:0] im_instruction;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        align_err;
    logic [31:0] fetch_count;

    // The fetch stage itself
    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, im_instruction,
        output im_address, ifid_instr, ifid_pc_plus4, ifid_valid, align_err, fetch_count
    );

    // Hazard unit, ID stage and instruction memory
    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, im_instruction,
        input  im_address, ifid_instr, ifid_pc_plus4, ifid_valid, align_err, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// =============================================================================
// fetch_stage : MIPS IF stage - PC register, IM addressing, IF/ID register
// Revision: 1.0
// =============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          IM_WORDS  = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    // IM_WORDS is a power of two, so the wrap is a simple byte-address mask
    localparam logic [31:0] C_ADDR_MASK = 32'(IM_WORDS * 4 - 1);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;
    logic        r_align_err;
    logic [31:0] r_fetch_count;

    logic        w_redirect;
    logic [31:0] w_raw_target;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_redirect   = bus.jump | bus.branch_taken;
    assign w_raw_target = bus.jump ? bus.jump_target : bus.branch_target;
    assign w_target     = {w_raw_target[31:2], 2'b00};
    assign w_pc_plus4   = (r_pc + 32'd4) & C_ADDR_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= RESET_PC + 32'd4;
            r_ifid_valid    <= 1'b0;
            r_align_err     <= 1'b0;
            r_fetch_count   <= 32'd0;
        end else if (w_redirect) begin
            // Redirect wins over stall and squashes the wrong-path fetch
            r_pc            <= w_target;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= w_pc_plus4;
            r_ifid_valid    <= 1'b0;
            if (w_raw_target[1:0] != 2'b00) begin
                r_align_err <= 1'b1;
            end
        end else if (!bus.stall) begin
            r_pc            <= w_pc_plus4;
            r_ifid_instr    <= bus.im_instruction;
            r_ifid_pc_plus4 <= w_pc_plus4;
            r_ifid_valid    <= 1'b1;
            r_fetch_count   <= r_fetch_count + 32'd1;
        end
    end

    assign bus.im_address    = r_pc;
    assign bus.ifid_instr    = r_ifid_instr;
    assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
    assign bus.ifid_valid    = r_ifid_valid;
    assign bus.align_err     = r_align_err;
    assign bus.fetch_count   = r_fetch_count;
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// =============================================================================
// tb_fetch_stage : directed bench with a spec-level model checked every cycle
// Revision: 1.0
// =============================================================================
module tb_fetch_stage;
    localparam int          IM_WORDS  = 256;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic clk;
    logic rst_n;
    fetch_stage_if fif ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP_INSTR),
        .IM_WORDS  (IM_WORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fif)
    );

    logic [31:0] im [IM_WORDS];
    assign fif.im_instruction = im[fif.im_address[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_pc, m_instr, m_pcp4, m_count;
    logic        m_valid, m_align;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc    = 32'h0;
        m_instr = NOP_INSTR;
        m_pcp4  = 32'h4;
        m_valid = 1'b0;
        m_align = 1'b0;
        m_count = 32'h0;
    endtask

    task automatic m_step();
        logic [31:0] tgt;
        logic [31:0] nxt;
        int          idx;
        nxt = (m_pc + 32'd4) % 32'(IM_WORDS * 4);
        if (fif.jump || fif.branch_taken) begin
            tgt = fif.jump ? fif.jump_target : fif.branch_target;
            if (tgt % 4 != 0) m_align = 1'b1;
            m_pc    = tgt - (tgt % 4);
            m_instr = NOP_INSTR;
            m_pcp4  = nxt;
            m_valid = 1'b0;
        end else if (!fif.stall) begin
            idx     = int'((m_pc / 4) % 32'(IM_WORDS));
            m_instr = im[idx];
            m_pc    = nxt;
            m_pcp4  = nxt;
            m_valid = 1'b1;
            m_count = m_count + 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst_n === 1'b1) m_step();
    end

    // Cycle-by-cycle compare against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("im_address",    fif.im_address,    m_pc);
            chk("ifid_instr",    fif.ifid_instr,    m_instr);
            chk("ifid_pc_plus4", fif.ifid_pc_plus4, m_pcp4);
            chk("ifid_valid",    32'(fif.ifid_valid), 32'(m_valid));
            chk("align_err",     32'(fif.align_err),  32'(m_align));
            chk("fetch_count",   fif.fetch_count,   m_count);
        end
    end

    task automatic idle_inputs();
        fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = 32'h0;
        fif.jump  = 1'b0; fif.jump_target  = 32'h0;
    endtask

    task automatic step(input logic s, input logic bt, input logic [31:0] bta,
                        input logic j, input logic [31:0] ja);
        fif.stall = s; fif.branch_taken = bt; fif.branch_target = bta;
        fif.jump  = j; fif.jump_target  = ja;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < IM_WORDS; i++) im[i] = 32'h2000_0000 + 32'(i);
        im[0] = 32'h8c05_0014;
        im[1] = 32'h8c0a_0014;
        idle_inputs();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_im_address", fif.im_address, 32'h0);
        chk("rst_ifid_pcp4",  fif.ifid_pc_plus4, 32'h4);
        chk("rst_valid",      32'(fif.ifid_valid), 32'h0);

        // Two sequential fetches
        step(0, 0, 0, 0, 0);
        chk("f1_instr", fif.ifid_instr, 32'h8c05_0014);
        chk("f1_pcp4",  fif.ifid_pc_plus4, 32'h4);
        step(0, 0, 0, 0, 0);
        chk("f2_instr", fif.ifid_instr, 32'h8c0a_0014);
        chk("f2_pcp4",  fif.ifid_pc_plus4, 32'h8);
        chk("f2_count", fif.fetch_count, 32'd2);

        // Three-cycle stall at PC=8
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, 0);
            chk("stall_addr",  fif.im_address, 32'h8);
            chk("stall_instr", fif.ifid_instr, 32'h8c0a_0014);
            chk("stall_count", fif.fetch_count, 32'd2);
        end
        step(0, 0, 0, 0, 0);
        chk("resume_instr", fif.ifid_instr, 32'h2000_0002);
        chk("resume_addr",  fif.im_address, 32'hC);

        // Taken branch to 0x40 from PC=0xC
        step(0, 1, 32'h40, 0, 0);
        chk("br_addr",  fif.im_address, 32'h40);
        chk("br_valid", 32'(fif.ifid_valid), 32'h0);
        chk("br_pcp4",  fif.ifid_pc_plus4, 32'h10);
        step(0, 0, 0, 0, 0);
        chk("br_tgt_pcp4",  fif.ifid_pc_plus4, 32'h44);
        chk("br_tgt_instr", fif.ifid_instr, 32'h2000_0010);

        // Jump and branch together under stall: jump wins, bubble inserted
        step(1, 1, 32'h40, 1, 32'h80);
        chk("jb_addr",  fif.im_address, 32'h80);
        chk("jb_valid", 32'(fif.ifid_valid), 32'h0);
        chk("jb_count", fif.fetch_count, 32'd4);
        step(0, 0, 0, 0, 0);
        chk("jb_tgt_instr", fif.ifid_instr, 32'h2000_0020);

        // Misaligned jump target
        step(0, 0, 0, 1, 32'h42);
        chk("mis_addr",  fif.im_address, 32'h40);
        chk("mis_align", 32'(fif.align_err), 32'h1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("mis_sticky", 32'(fif.align_err), 32'h1);

        // Async reset pulse with a pending redirect and stall
        #2;
        rst_n = 1'b0;
        fif.stall = 1'b1; fif.jump = 1'b1; fif.jump_target = 32'h100;
        m_reset();
        #1;
        chk("arst_addr",  fif.im_address, 32'h0);
        chk("arst_align", 32'(fif.align_err), 32'h0);
        chk("arst_count", fif.fetch_count, 32'h0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("post_rst_instr", fif.ifid_instr, 32'h8c05_0014);
        chk("post_rst_count", fif.fetch_count, 32'd1);

        // Wrap from the top IM word
        step(0, 0, 0, 1, 32'h3FC);
        chk("wrap_jaddr", fif.im_address, 32'h3FC);
        step(0, 0, 0, 0, 0);
        chk("wrap_addr",  fif.im_address, 32'h0);
        chk("wrap_pcp4",  fif.ifid_pc_plus4, 32'h0);
        chk("wrap_instr", fif.ifid_instr, 32'h2000_00FF);
        step(0, 0, 0, 0, 0);
        chk("wrap_next",  fif.ifid_instr, 32'h8c05_0014);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
